// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, writeback port and issue/scoreboard handshake.
interface reg_file_sb_if #(
  parameter int unsigned REG_WORD_WIDTH = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ_PORTS = 2
);
  localparam int unsigned W  = REG_WORD_WIDTH;
  localparam int unsigned AW = REG_ADDR_WIDTH;
  localparam int unsigned NR = NUM_READ_PORTS;

  logic [NR*AW-1:0] read_reg_i;
  logic [NR*W-1:0]  read_data_o;
  logic [NR-1:0]    read_busy_o;
  logic             write_en_i;
  logic [AW-1:0]    write_reg_i;
  logic [W-1:0]     write_data_i;
  logic             issue_en_i;
  logic [AW-1:0]    issue_reg_i;
  logic             issue_ready_o;
  logic [AW:0]      busy_count_o;

  modport master (
    output read_reg_i, write_en_i, write_reg_i, write_data_i, issue_en_i, issue_reg_i,
    input  read_data_o, read_busy_o, issue_ready_o, busy_count_o
  );

  modport slave (
    input  read_reg_i, write_en_i, write_reg_i, write_data_i, issue_en_i, issue_reg_i,
    output read_data_o, read_busy_o, issue_ready_o, busy_count_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file (r0 = 0) with optional write bypass and a per-register
// busy scoreboard that gates instruction issue on outstanding destinations.
module reg_file_sb #(
  parameter int unsigned REG_WORD_WIDTH = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned BYPASS_EN      = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam int unsigned W     = REG_WORD_WIDTH;
  localparam int unsigned AW    = REG_ADDR_WIDTH;
  localparam int unsigned NR    = NUM_READ_PORTS;
  localparam int unsigned NREGS = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam logic        BYP   = (BYPASS_EN != 0);

  logic [W-1:0]     regs_q [NREGS];
  logic [W-1:0]     regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_count_q, busy_count_d;

  logic             wr_hit;
  logic             issue_ready;
  logic             issue_set;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [NR*W-1:0]  read_data;
  logic [NR-1:0]    read_busy;
  logic [AW-1:0]    ra;

  // Writeback and issue decode; a same-cycle writeback to the issue target releases the hazard.
  always_comb begin
    wr_hit      = bus.write_en_i && (bus.write_reg_i != '0);
    issue_ready = (bus.issue_reg_i == '0) || !busy_q[bus.issue_reg_i] ||
                  (bus.write_en_i && (bus.write_reg_i == bus.issue_reg_i));
    issue_set   = bus.issue_en_i && issue_ready && (bus.issue_reg_i != '0);
  end

  // Next state: write clears busy, accepted issue sets it afterwards so issue wins on a collision.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_hit) begin
      regs_d[bus.write_reg_i] = bus.write_data_i;
      busy_d[bus.write_reg_i] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.issue_reg_i] = 1'b1;
    end
    cnt_inc      = issue_set && !busy_q[bus.issue_reg_i];
    cnt_dec      = wr_hit && busy_q[bus.write_reg_i] &&
                   !(issue_set && (bus.issue_reg_i == bus.write_reg_i));
    busy_count_d = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '{default: '0};
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Combinational read ports with optional forwarding of the in-flight writeback.
  always_comb begin
    read_data = '0;
    read_busy = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      ra = bus.read_reg_i[k*AW +: AW];
      if (ra != '0) begin
        if (BYP && bus.write_en_i && (bus.write_reg_i == ra)) begin
          read_data[k*W +: W] = bus.write_data_i;
        end else begin
          read_data[k*W +: W] = regs_q[ra];
          read_busy[k]        = busy_q[ra];
        end
      end
    end
  end

  assign bus.read_data_o   = read_data;
  assign bus.read_busy_o   = read_busy;
  assign bus.issue_ready_o = issue_ready;
  assign bus.busy_count_o  = busy_count_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus random checks of reg_file_sb (bypass and no-bypass builds) against an array model.
module tb_reg_file_sb;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] wr;
  logic [W-1:0]  wd;
  logic          ie;
  logic [AW-1:0] ir;
  logic [AW-1:0] rr0;
  logic [AW-1:0] rr1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mregs [32];
  bit           mbusy [32];

  reg_file_sb_if #(.REG_WORD_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR)) bus_b ();
  reg_file_sb_if #(.REG_WORD_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR)) bus_n ();

  assign bus_b.read_reg_i   = {rr1, rr0};
  assign bus_b.write_en_i   = we;
  assign bus_b.write_reg_i  = wr;
  assign bus_b.write_data_i = wd;
  assign bus_b.issue_en_i   = ie;
  assign bus_b.issue_reg_i  = ir;
  assign bus_n.read_reg_i   = {rr1, rr0};
  assign bus_n.write_en_i   = we;
  assign bus_n.write_reg_i  = wr;
  assign bus_n.write_data_i = wd;
  assign bus_n.issue_en_i   = ie;
  assign bus_n.issue_reg_i  = ir;

  reg_file_sb #(.REG_WORD_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR), .BYPASS_EN(1))
    u_dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  reg_file_sb #(.REG_WORD_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR), .BYPASS_EN(0))
    u_dut_nob (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += mbusy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [W-1:0] exp_data(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && we && (int'(wr) == a)) return wd;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    return mbusy[a] && !(byp && we && (int'(wr) == a));
  endfunction

  function automatic logic exp_ready();
    return (ir == '0) || !mbusy[ir] || (we && (wr == ir));
  endfunction

  function automatic logic [W-1:0] port_data(input logic [NR*W-1:0] v, input int k);
    logic [NR*W-1:0] t;
    t = v >> (k * W);
    return t[W-1:0];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic we_v, input int wr_v, input logic [W-1:0] wd_v,
                       input logic ie_v, input int ir_v, input int r0_v, input int r1_v);
    @(negedge clk);
    we  = we_v;
    wr  = AW'(wr_v);
    wd  = wd_v;
    ie  = ie_v;
    ir  = AW'(ir_v);
    rr0 = AW'(r0_v);
    rr1 = AW'(r1_v);
    #1;
  endtask

  // Compare every output of both builds against the model for the inputs currently applied.
  task automatic model_check(input string tag);
    int a [2];
    a[0] = int'(rr0);
    a[1] = int'(rr1);
    for (int k = 0; k < 2; k++) begin
      check({tag, "/byp_data"}, 64'(port_data(bus_b.read_data_o, k)), 64'(exp_data(a[k], 1'b1)));
      check({tag, "/byp_busy"}, 64'(bus_b.read_busy_o[k]), 64'(exp_busy(a[k], 1'b1)));
      check({tag, "/nob_data"}, 64'(port_data(bus_n.read_data_o, k)), 64'(exp_data(a[k], 1'b0)));
      check({tag, "/nob_busy"}, 64'(bus_n.read_busy_o[k]), 64'(exp_busy(a[k], 1'b0)));
    end
    check({tag, "/ready"}, 64'({bus_b.issue_ready_o, bus_n.issue_ready_o}), 64'({2{exp_ready()}}));
    check({tag, "/count_b"}, 64'(bus_b.busy_count_o), 64'(model_count()));
    check({tag, "/count_n"}, 64'(bus_n.busy_count_o), 64'(model_count()));
  endtask

  task automatic tick();
    logic rdy;
    rdy = exp_ready();
    @(posedge clk);
    if (we && (wr != '0)) begin
      mregs[wr] = wd;
      mbusy[wr] = 1'b0;
    end
    if (ie && rdy && (ir != '0)) mbusy[ir] = 1'b1;
  endtask

  task automatic step(input string tag, input logic we_v, input int wr_v, input logic [W-1:0] wd_v,
                      input logic ie_v, input int ir_v, input int r0_v, input int r1_v);
    drive(we_v, wr_v, wd_v, ie_v, ir_v, r0_v, r1_v);
    model_check(tag);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wr = '0; wd = '0; ie = 1'b0; ir = '0; rr0 = '0; rr1 = '0;
    reset_model();
    repeat (2) @(posedge clk);
    drive(1'b0, 0, '0, 1'b0, 0, 5, 31);
    model_check("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read and r0 hard-wired zero
    step("w5", 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0);
    drive(1'b0, 0, '0, 1'b0, 0, 5, 5);
    model_check("r5");
    check("r5_p0", 64'(port_data(bus_b.read_data_o, 0)), 64'h0000_0000_DEAD_BEEF);
    check("r5_p1", 64'(port_data(bus_b.read_data_o, 1)), 64'h0000_0000_DEAD_BEEF);
    tick();
    step("w0", 1'b1, 0, 32'h1234, 1'b0, 0, 0, 0);
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
    model_check("r0");
    check("r0_zero", 64'(port_data(bus_b.read_data_o, 0)), 64'h0);
    tick();

    // Bypass vs stored value on same-cycle write
    step("w7_old", 1'b1, 7, 32'h1111_1111, 1'b0, 0, 0, 0);
    drive(1'b1, 7, 32'hA5A5A5A5, 1'b0, 0, 0, 7);
    model_check("byp7");
    check("byp7_fwd", 64'(port_data(bus_b.read_data_o, 1)), 64'hA5A5_A5A5);
    check("byp7_busy", 64'(bus_b.read_busy_o[1]), 64'h0);
    check("nob7_old", 64'(port_data(bus_n.read_data_o, 1)), 64'h1111_1111);
    tick();

    // Scoreboard: issue, blocked re-issue, writeback release
    drive(1'b0, 0, '0, 1'b1, 3, 0, 0);
    model_check("iss3");
    check("iss3_ready", 64'(bus_b.issue_ready_o), 64'h1);
    tick();
    drive(1'b0, 0, '0, 1'b1, 3, 3, 0);
    model_check("reiss3");
    check("reiss3_busy", 64'(bus_b.read_busy_o[0]), 64'h1);
    check("reiss3_cnt", 64'(bus_b.busy_count_o), 64'h1);
    check("reiss3_rdy", 64'(bus_b.issue_ready_o), 64'h0);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 3, 0);
    check("hold3_cnt", 64'(bus_b.busy_count_o), 64'h1);
    tick();
    step("wb3", 1'b1, 3, 32'h33, 1'b0, 0, 3, 0);
    drive(1'b0, 0, '0, 1'b0, 0, 3, 0);
    model_check("free3");
    check("free3_busy", 64'(bus_b.read_busy_o[0]), 64'h0);
    check("free3_cnt", 64'(bus_b.busy_count_o), 64'h0);
    tick();

    // Issue and write of the same busy register in one cycle
    step("iss3b", 1'b0, 0, '0, 1'b1, 3, 0, 0);
    drive(1'b1, 3, 32'h55, 1'b1, 3, 0, 0);
    model_check("coll3");
    check("coll3_rdy", 64'(bus_b.issue_ready_o), 64'h1);
    tick();
    drive(1'b0, 0, '0, 1'b0, 0, 3, 3);
    model_check("post_coll3");
    check("coll3_data", 64'(port_data(bus_n.read_data_o, 0)), 64'h55);
    check("coll3_busy", 64'(bus_b.read_busy_o[0]), 64'h1);
    check("coll3_cnt", 64'(bus_b.busy_count_o), 64'h1);
    tick();
    step("wb3b", 1'b1, 3, 32'h66, 1'b0, 0, 0, 0);

    // Fill and drain the whole scoreboard
    for (int i = 1; i < 32; i++) step("fill", 1'b0, 0, '0, 1'b1, i, i, 32 - i);
    drive(1'b0, 0, '0, 1'b0, 0, 31, 1);
    model_check("full");
    check("full_cnt", 64'(bus_b.busy_count_o), 64'd31);
    tick();
    for (int i = 1; i < 32; i++) step("drain", 1'b1, i, $urandom, 1'b0, 0, i, 1);
    drive(1'b0, 0, '0, 1'b0, 0, 1, 31);
    model_check("empty");
    check("empty_cnt", 64'(bus_b.busy_count_o), 64'd0);
    tick();

    // Random issue/writeback/read mix with hazards concentrated on a few registers
    for (int n = 0; n < 400; n++) begin
      int wr_v, ir_v, r0_v, r1_v;
      wr_v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      ir_v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      r0_v = ($urandom_range(0, 3) == 0) ? wr_v : int'($urandom_range(0, 31));
      r1_v = ($urandom_range(0, 3) == 0) ? ir_v : int'($urandom_range(0, 31));
      step("rand", 1'($urandom_range(0, 1)), wr_v, $urandom, 1'($urandom_range(0, 1)), ir_v, r0_v, r1_v);
    end

    // Mid-run async reset with a write and an issue in flight
    step("pre_rst_w", 1'b1, 12, 32'hCAFE_F00D, 1'b1, 13, 0, 0);
    drive(1'b1, 9, 32'h9999_9999, 1'b1, 10, 12, 13);
    rst_n = 1'b0;
    #1;
    reset_model();
    model_check("rst_async");
    check("rst_cnt", 64'(bus_b.busy_count_o), 64'h0);
    for (int a = 1; a < 32; a++) begin
      if (a == 9) continue;
      rr0 = AW'(a);
      rr1 = AW'(31 - a + 1);
      #1;
      check("rst_rd", 64'(bus_n.read_data_o), 64'h0);
      check("rst_busy", 64'({bus_b.read_busy_o, bus_n.read_busy_o}), 64'h0);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    ie = 1'b0;
    rr0 = 5'd9;
    rr1 = 5'd10;
    #1;
    check("rst_discard", 64'({bus_n.read_data_o, 2'(bus_b.read_busy_o)}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      step("post_rst", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
